// File: rtl/pc_sequencer.sv
// Hack-style program counter sequencer: IDLE/FETCH/EXEC with
// sticky jump-to-self halt and sticky fetch-timeout fault.
module pc_sequencer #(
  parameter int FETCH_TIMEOUT = 8,
  parameter int HALT_DETECT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  input  logic        alu_zr,
  input  logic        alu_ng,
  input  logic [14:0] a_reg,
  output logic [14:0] pc,
  output logic        fetch_req,
  output logic        exec_en,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired
);

  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(FETCH_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT,
    FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [14:0]   pc_q, pc_d;
  logic [15:0]   retired_q, retired_d;
  logic [15:0]   ir_q, ir_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          fetch_q, exec_q, halt_q, fault_q;
  logic          taken, self_jump;

  assign taken = ir_q[15] & (
    (ir_q[2] & alu_ng) |
    (ir_q[1] & alu_zr) |
    (ir_q[0] & ~alu_ng & ~alu_zr));

  assign self_jump = (HALT_DETECT != 0) &
    taken & (a_reg == pc_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TO_MAX) state_d = FAULT;
        end
      end
      EXEC: begin
        pc_d  = taken ? a_reg : pc_q + 15'd1;
        cnt_d = '0;
        if (retired_q != 16'hFFFF)
          retired_d = retired_q + 16'd1;
        if (self_jump)
          state_d = HALT;
        else if (!run)
          state_d = IDLE;
        else
          state_d = FETCH;
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      ir_q      <= '0;
      cnt_q     <= '0;
      fetch_q   <= 1'b0;
      exec_q    <= 1'b0;
      halt_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      fetch_q   <= (state_d == FETCH);
      exec_q    <= (state_d == EXEC);
      halt_q    <= (state_d == HALT);
      fault_q   <= (state_d == FAULT);
    end
  end

  assign pc        = pc_q;
  assign retired   = retired_q;
  assign fetch_req = fetch_q;
  assign exec_en   = exec_q;
  assign halted    = halt_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random
// stimulus against a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam int FT = 8;
  localparam int MI = 0;
  localparam int MF = 1;
  localparam int ME = 2;
  localparam int MH = 3;
  localparam int MX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        instr_valid;
  logic [15:0] instr;
  logic        alu_zr;
  logic        alu_ng;
  logic [14:0] a_reg;
  logic [14:0] pc;
  logic        fetch_req;
  logic        exec_en;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  int          m_mode;
  int          m_to;
  logic [14:0] m_pc;
  logic [15:0] m_ret;
  logic [15:0] m_ir;

  pc_sequencer #(
    .FETCH_TIMEOUT(FT),
    .HALT_DETECT(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .instr_valid(instr_valid),
    .instr(instr),
    .alu_zr(alu_zr),
    .alu_ng(alu_ng),
    .a_reg(a_reg),
    .pc(pc),
    .fetch_req(fetch_req),
    .exec_en(exec_en),
    .halted(halted),
    .fault(fault),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = MI;
    m_to   = 0;
    m_pc   = '0;
    m_ret  = '0;
    m_ir   = '0;
  endtask

  task automatic model_step();
    int   r;
    logic tk;
    case (m_mode)
      MI: if (run) begin
        m_mode = MF;
        m_to   = 0;
      end
      MF: if (instr_valid) begin
        m_ir   = instr;
        m_mode = ME;
      end else begin
        m_to++;
        if (m_to >= FT) m_mode = MX;
      end
      ME: begin
        tk = m_ir[15] && ((m_ir[2] && alu_ng) ||
             (m_ir[1] && alu_zr) ||
             (m_ir[0] && !alu_ng && !alu_zr));
        r = int'(m_ret) + 1;
        if (r > 65535) r = 65535;
        m_ret = 16'(r);
        if (tk && a_reg == m_pc) begin
          m_pc   = a_reg;
          m_mode = MH;
        end else begin
          m_pc = tk ? a_reg
                    : 15'((int'(m_pc) + 1) % 32768);
          m_mode = run ? MF : MI;
          m_to   = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("retired", 32'(retired), 32'(m_ret));
    chk("fetch_req", 32'(fetch_req), 32'(m_mode == MF));
    chk("exec_en", 32'(exec_en), 32'(m_mode == ME));
    chk("halted", 32'(halted), 32'(m_mode == MH));
    chk("fault", 32'(fault), 32'(m_mode == MX));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int ivp;
    reset       = 1'b0;
    run         = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    alu_zr      = 1'b0;
    alu_ng      = 1'b0;
    a_reg       = '0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ret", 32'(retired), 32'h0);
    #1;
    reset = 1'b1;

    run = 1'b1;
    instr_valid = 1'b1;
    instr = 16'h0005;
    repeat (9) tick();
    chk("seq_pc", 32'(pc), 32'h4);
    chk("seq_ret", 32'(retired), 32'h4);

    instr = 16'hE302;
    alu_zr = 1'b1;
    a_reg = 15'h0BCD;
    tick();
    chk("jeq_exec", 32'(exec_en), 32'h1);
    tick();
    chk("jeq_taken", 32'(pc), 32'h0BCD);
    alu_zr = 1'b0;
    tick();
    tick();
    chk("jeq_not", 32'(pc), 32'h0BCE);

    instr = 16'hE007;
    a_reg = 15'h0010;
    tick();
    tick();
    chk("jmp_pc", 32'(pc), 32'h0010);
    instr = 16'hEA87;
    tick();
    tick();
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_pc", 32'(pc), 32'h0010);
    chk("halt_ret", 32'(retired), 32'h8);
    repeat (6) begin
      run = ~run;
      tick();
    end
    chk("halt_stay", 32'(halted), 32'h1);
    chk("halt_pc2", 32'(pc), 32'h0010);

    run = 1'b1;
    do_reset();
    instr = 16'hE007;
    a_reg = 15'h1234;
    repeat (3) tick();
    instr_valid = 1'b0;
    repeat (7) tick();
    chk("to_fetch7", 32'(fetch_req), 32'h1);
    tick();
    chk("to_fault", 32'(fault), 32'h1);
    chk("to_freq", 32'(fetch_req), 32'h0);
    chk("to_pc", 32'(pc), 32'h1234);

    do_reset();
    instr_valid = 1'b1;
    a_reg = 15'h7FFF;
    repeat (3) tick();
    chk("wrap_pre", 32'(pc), 32'h7FFF);
    instr = 16'h0005;
    tick();
    tick();
    chk("wrap_pc", 32'(pc), 32'h0000);
    run = 1'b0;
    tick();
    tick();
    force dut.retired_q = 16'hFFFD;
    m_ret = 16'hFFFD;
    tick();
    release dut.retired_q;
    tick();
    run = 1'b1;
    repeat (9) tick();
    chk("sat_ret", 32'(retired), 32'hFFFF);

    tick();
    chk("mid_exec", 32'(exec_en), 32'h1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_pc", 32'(pc), 32'h0);
    chk("async_ret", 32'(retired), 32'h0);
    chk("async_exec", 32'(exec_en), 32'h0);
    compare_all();
    #1;
    reset = 1'b1;

    ivp = 70;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        case ($urandom % 3)
          0: ivp = 30;
          1: ivp = 70;
          default: ivp = 100;
        endcase
      end
      run = ($urandom % 8) != 0;
      instr_valid = ($urandom % 100) < ivp;
      if ($urandom % 4 == 0)
        instr = 16'($urandom) & 16'h7FFF;
      else
        instr = 16'hE000 | 16'($urandom % 8);
      alu_zr = 1'($urandom);
      alu_ng = 1'($urandom);
      if ($urandom % 4 == 0)
        a_reg = m_pc;
      else
        a_reg = 15'($urandom);
      tick();
      if ((m_mode == MH || m_mode == MX) &&
          $urandom % 6 == 0)
        do_reset();
      else if ($urandom % 200 == 0)
        do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The parameter list SHALL be exactly:
- FETCH_TIMEOUT, default 8: max FETCH cycles without instr_valid before fault.
- HALT_DETECT, default 1: 1 enables jump-to-self halt detection; 0 disables it.

REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.

REQ-003 The ports SHALL be exactly (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- run, in, 1: enables sequencing.
- instr_valid, in, 1: instruction memory returns instr this cycle.
- instr, in, 16: Hack instruction word.
- alu_zr, in, 1: ALU zero flag, valid during EXEC.
- alu_ng, in, 1: ALU negative flag, valid during EXEC.
- a_reg, in, 15: jump target (A register low 15 bits).
- pc, out, 15: current program counter, registered.
- fetch_req, out, 1: high while in FETCH.
- exec_en, out, 1: one-cycle commit strobe, high only in EXEC.
- halted, out, 1: sticky jump-to-self indication.
- fault, out, 1: sticky fetch timeout indication.
- retired, out, 16: count of executed instructions.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, FETCH, EXEC, HALT and FAULT.

REQ-005 IDLE behaviour SHALL be:
- pc held.
- run=1 -> FETCH next cycle.
- instr_valid ignored.

REQ-006 FETCH behaviour SHALL be:
- fetch_req=1.
- instr_valid=1 -> latch instr, go to EXEC next cycle.
- run deasserting during FETCH does not abort the fetch.

REQ-007 The timeout counter SHALL:
- clear on FETCH entry;
- increment for each FETCH cycle with instr_valid=0;
- on reaching FETCH_TIMEOUT, go to FAULT next cycle.

REQ-008 EXEC SHALL last exactly one cycle with exec_en=1, using the latched instruction and the live alu_zr, alu_ng and a_reg values.

REQ-009 The jump decision SHALL be:
- taken = latched[15] AND ((latched[2] AND alu_ng) OR (latched[1] AND alu_zr) OR (latched[0] AND NOT alu_ng AND NOT alu_zr));
- A-instructions (bit15=0) are never taken.

REQ-010 On EXEC exit, pc SHALL load a_reg when taken, else pc+1 modulo 2^15 (0x7FFF wraps to 0x0000).

REQ-011 Each EXEC cycle SHALL increment retired, saturating at 0xFFFF.

REQ-012 EXEC exit priority SHALL be:
- (HALT_DETECT=1 AND taken AND a_reg==pc) -> HALT, with pc loaded to a_reg;
- else run=0 -> IDLE;
- else FETCH.

REQ-013 HALT SHALL:
- assert halted=1;
- hold pc and retired;
- remain in HALT until reset.

REQ-014 FAULT SHALL:
- assert fault=1;
- hold pc and retired;
- remain in FAULT until reset.

REQ-015 fetch_req, exec_en, halted and fault SHALL be mutually exclusive and registered, with no combinational input-to-output paths.

Reset
REQ-016 reset=0 SHALL, asynchronously and regardless of state:
- force state to IDLE;
- force pc=0x0000 and retired=0x0000;
- force fetch_req, exec_en, halted and fault to 0;
- clear the latched instruction and the timeout counter.

REQ-017 After reset deasserts, the first FSM transition SHALL occur on the first rising clk edge.

REQ-018 Reset asserted mid-FETCH or mid-EXEC SHALL discard the in-flight instruction without incrementing retired.

Verification
REQ-019 The bench SHALL cover at least these directed scenarios:
- Sequential: run=1, instr=0x0005 (A-instr), instr_valid=1 each FETCH, 4 instructions -> pc 0,1,2,3,4; retired=4; exec_en pulses once per 2 cycles.
- Taken jump: instr=0xE302 (JEQ), alu_zr=1, a_reg=0x0BCD -> pc=0x0BCD after EXEC; with alu_zr=0 -> pc=prev+1.
- Halt: pc=0x0010, instr=0xEA87 (JMP), a_reg=0x0010 -> halted=1 next cycle; pc stays 0x0010; run toggling has no effect.
- Timeout: FETCH with instr_valid=0 for 8 cycles -> fault=1, fetch_req=0, pc unchanged.
- Wrap and saturate: pc preset to 0x7FFF via jump, then non-jump -> pc=0x0000; retired driven past 0xFFFF stays 0xFFFF.
- Reset mid-EXEC: reset=0 during exec_en=1 -> pc=0, retired=0, state IDLE immediately, without waiting for a clock edge.
